b16_memctl: RTL and testbench
=============================

// Module: b16_memctl
// PURPOSE
//  Parametrised memory controller for the b16 SoC: arbitrates CPU vs debug-UART bus, decodes SFR/boot-RAM/SRAM,
//  runs async-SRAM wait states via an FSM, and returns a one-cycle ready pulse. Replaces ad-hoc top-level glue.
// PARAMETERS
//  AW         16     bus address width (byte address, bit 0 ignored)
//  SRAM_AW    18     external SRAM word-address width (>= AW-1)
//  BOOT_AW    12     boot RAM depth = 2**BOOT_AW 16-bit words
//  SFR_PAGE   8'hFF  addr[AW-1:AW-8] value selecting SFR space
//  BOOT_TAG   3'h1   addr[AW-1:AW-3] value selecting boot RAM (SFR match wins)
//  SRAM_WAIT  3      SRAM strobe cycles per access (1..15)
//  SFR_TMO    15     SFR ack timeout cycles (MEMCTL_SFR_TIMEOUT_EN only)
// PORTS
//  clk        in  1        system clock
//  reset      in  1        synchronous, active-high
//  cpu_addr   in  AW       CPU address;  cpu_r in 1 read; cpu_w in 2 byte write strobes [1]=hi [0]=lo
//  cpu_wdata  in  16       CPU write data
//  cpu_rdata  out 16       read data, valid while cpu_ready
//  cpu_ready  out 1        one-cycle completion pulse
//  dbg_cs     in  1        debug master requests the bus
//  dbg_addr   in  AW;  dbg_r in 1;  dbg_w in 2;  dbg_wdata in 16   debug request (same encoding as cpu_*)
//  dbg_rdata  out 16;  dbg_ready out 1                             debug completion
//  sfr_sel    out 1        SFR access strobe
//  sfr_addr   out 8;  sfr_r out 1;  sfr_w out 2;  sfr_wdata out 16  latched SFR request
//  sfr_rdata  in  16       SFR read data
//  sfr_ack    in  1        SFR completion (used only with MEMCTL_SFR_TIMEOUT_EN)
//  sram_bank  in  SRAM_AW-AW+1  upper SRAM word-address bits
//  sram_addr  out SRAM_AW  {sram_bank, addr[AW-1:1]}
//  sram_dq_i  in  16;  sram_dq_o out 16;  sram_dq_oe out 1        split tristate data bus
//  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out 1 each  SRAM strobes
//  bus_err    out 1        one-cycle pulse on SFR timeout (0 without macro)
// BEHAVIOUR
//  - Request = r | (|w). r set -> read, w ignored. w==2'b00 and !r -> no request.
//  - Arbitration in IDLE only: dbg_cs & dbg request wins over CPU. Grant, addr, strobes, wdata latched at accept;
//    master must hold request until its ready pulse, then drop or change it the next cycle.
//  - FSM IDLE -> {BOOT | SFR | SRAM} -> DONE -> IDLE. DONE drives granted master's ready=1 and rdata for one cycle.
//  - BOOT: 1 cycle; write per-byte to word addr[BOOT_AW:1]; read registered. Accept->ready = 2 cycles.
//  - SFR (no macro): sfr_sel=1 for 1 cycle, sfr_rdata captured, accept->ready = 2 cycles.
//  - SRAM: counter loads SRAM_WAIT-1; ce_n=0 all cycles; read: oe_n=0, dq_oe=0, sram_dq_i captured on last cycle;
//    write: dq_oe=1, we_n=0 except last cycle (data hold). ub_n/lb_n = 0 on read, ~w[1]/~w[0] on write.
//    Accept->ready = SRAM_WAIT+1 cycles. Counter decrements to 0, never wraps.
//  - Non-granted master ready=0; its rdata holds last value. Boot/SRAM addresses wrap modulo depth.
//  - Reset (also mid-access): next edge -> IDLE; readys, sfr_sel, bus_err, dq_oe = 0; ce_n/oe_n/we_n/ub_n/lb_n = 1;
//    rdata = 0. Boot RAM contents not cleared. Aborted write may be partial.
// CONFIGURATION
//  MEMCTL_SFR_TIMEOUT_EN defined: SFR holds sfr_sel until sfr_ack; ack captures sfr_rdata -> DONE. No ack after
//    SFR_TMO cycles -> DONE, rdata=16'hDEAD, bus_err=1 same cycle as ready.
//  Undefined: fixed 1-cycle SFR; sfr_ack ignored; bus_err tied 0.
// TESTING
//  1 CPU write 16'hBEEF to 16'h2004 w=2'b11, then read -> ready 2 cycles after accept, rdata=16'hBEEF.
//  2 CPU read 16'h8000, SRAM_WAIT=3, sram_dq_i=16'h1234 -> oe_n low 3 cycles, ready at cycle 4, rdata=16'h1234.
//  3 Byte write w=2'b01 data 16'hAA55 to SRAM -> lb_n=0, ub_n=1, we_n low 2 cycles, dq_o=16'hAA55.
//  4 CPU and dbg request same IDLE cycle -> dbg_ready first; CPU accepted next IDLE, cpu_ready SRAM_WAIT+1 later.
//  5 Macro on, SFR read 16'hFF10, sfr_ack never -> ready+bus_err after SFR_TMO cycles, rdata=16'hDEAD.
//  6 reset during SRAM write cycle 2 -> next edge ce_n=we_n=1, dq_oe=0, ready=0, FSM IDLE.

Source files
------------

// File: rtl/b16_memctl.sv
// b16 memory controller: debug/CPU arbitration, SFR/boot-RAM/SRAM decode, SRAM wait-state FSM.
// Optional feature macro: MEMCTL_SFR_TIMEOUT_EN (SFR handshake with ack timeout and bus_err).
module b16_memctl #(
  parameter int          AW        = 16,
  parameter int          SRAM_AW   = 18,
  parameter int          BOOT_AW   = 12,
  parameter logic [7:0]  SFR_PAGE  = 8'hFF,
  parameter logic [2:0]  BOOT_TAG  = 3'h1,
  parameter int          SRAM_WAIT = 3,
  parameter int          SFR_TMO   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         cpu_addr,
  input  logic                  cpu_r,
  input  logic [1:0]            cpu_w,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  dbg_cs,
  input  logic [AW-1:0]         dbg_addr,
  input  logic                  dbg_r,
  input  logic [1:0]            dbg_w,
  input  logic [15:0]           dbg_wdata,
  output logic [15:0]           dbg_rdata,
  output logic                  dbg_ready,
  output logic                  sfr_sel,
  output logic [7:0]            sfr_addr,
  output logic                  sfr_r,
  output logic [1:0]            sfr_w,
  output logic [15:0]           sfr_wdata,
  input  logic [15:0]           sfr_rdata,
  input  logic                  sfr_ack,
  input  logic [SRAM_AW-AW:0]   sram_bank,
  output logic [SRAM_AW-1:0]    sram_addr,
  input  logic [15:0]           sram_dq_i,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n,
  output logic                  bus_err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BOOT = 3'd1,
    ST_SFR  = 3'd2,
    ST_SRAM = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic           gnt_dbg_r;
  logic [AW-1:0]  addr_r;
  logic           rd_r;
  logic [1:0]     w_r;
  logic [15:0]    wdata_r;
  logic [3:0]     cnt_r;
  logic [15:0]    cpu_rdata_r, dbg_rdata_r;
  logic [15:0]    boot_mem [0:(1<<BOOT_AW)-1];

  logic           cpu_req_s, dbg_req_s, req_s;
  logic [AW-1:0]  req_addr_s;
  logic           req_r_s;
  logic [1:0]     req_w_s;
  logic [15:0]    req_wdata_s;
  logic           is_sfr_s, is_boot_s;
  logic [15:0]    data_s;
  logic           load_s;
  logic [BOOT_AW-1:0] boot_idx_s;

`ifdef MEMCTL_SFR_TIMEOUT_EN
  localparam int TW = $clog2(SFR_TMO + 1);
  logic [TW-1:0]  tmo_r;
  logic           err_r;
  logic           tmo_last_s;
  assign tmo_last_s = (tmo_r == TW'(SFR_TMO - 1));
`else
  logic           unused_sfr_ack;
  assign unused_sfr_ack = sfr_ack;
`endif

  assign cpu_req_s  = cpu_r | (|cpu_w);
  assign dbg_req_s  = dbg_cs & (dbg_r | (|dbg_w));
  assign req_s      = cpu_req_s | dbg_req_s;
  assign boot_idx_s = addr_r[BOOT_AW:1];

  // Request mux: debug master has priority over the CPU
  always_comb begin
    if (dbg_req_s) begin
      req_addr_s  = dbg_addr;
      req_r_s     = dbg_r;
      req_w_s     = dbg_w;
      req_wdata_s = dbg_wdata;
    end else begin
      req_addr_s  = cpu_addr;
      req_r_s     = cpu_r;
      req_w_s     = cpu_w;
      req_wdata_s = cpu_wdata;
    end
    is_sfr_s  = (req_addr_s[AW-1:AW-8] == SFR_PAGE);
    is_boot_s = (req_addr_s[AW-1:AW-3] == BOOT_TAG);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_s)          state_s = ST_IDLE;
        else if (is_sfr_s)   state_s = ST_SFR;
        else if (is_boot_s)  state_s = ST_BOOT;
        else                 state_s = ST_SRAM;
      end
      ST_BOOT: state_s = ST_DONE;
`ifdef MEMCTL_SFR_TIMEOUT_EN
      ST_SFR: begin
        if (sfr_ack || tmo_last_s) state_s = ST_DONE;
        else                       state_s = ST_SFR;
      end
`else
      ST_SFR:  state_s = ST_DONE;
`endif
      ST_SRAM: begin
        if (cnt_r == 4'd0) state_s = ST_DONE;
        else               state_s = ST_SRAM;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Read-data source for the access that is completing this cycle
  always_comb begin
    data_s = 16'h0000;
    load_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        data_s = boot_mem[boot_idx_s];
        load_s = rd_r;
      end
      ST_SFR: begin
`ifdef MEMCTL_SFR_TIMEOUT_EN
        if (!sfr_ack && tmo_last_s) begin
          data_s = 16'hDEAD;
          load_s = 1'b1;
        end else begin
          data_s = sfr_rdata;
          load_s = rd_r && sfr_ack;
        end
`else
        data_s = sfr_rdata;
        load_s = rd_r;
`endif
      end
      ST_SRAM: begin
        data_s = sram_dq_i;
        load_s = rd_r && (cnt_r == 4'd0);
      end
      default: begin
        data_s = 16'h0000;
        load_s = 1'b0;
      end
    endcase
  end

  // State register, request latch, wait counter and per-master read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      gnt_dbg_r   <= 1'b0;
      addr_r      <= '0;
      rd_r        <= 1'b0;
      w_r         <= 2'b00;
      wdata_r     <= 16'h0000;
      cnt_r       <= 4'd0;
      cpu_rdata_r <= 16'h0000;
      dbg_rdata_r <= 16'h0000;
`ifdef MEMCTL_SFR_TIMEOUT_EN
      tmo_r       <= '0;
      err_r       <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && req_s) begin
        gnt_dbg_r <= dbg_req_s;
        addr_r    <= req_addr_s;
        rd_r      <= req_r_s;
        w_r       <= req_r_s ? 2'b00 : req_w_s;
        wdata_r   <= req_wdata_s;
        cnt_r     <= 4'(SRAM_WAIT - 1);
`ifdef MEMCTL_SFR_TIMEOUT_EN
        tmo_r     <= '0;
        err_r     <= 1'b0;
`endif
      end else if (state_r == ST_SRAM && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
`ifdef MEMCTL_SFR_TIMEOUT_EN
      if (state_r == ST_SFR) begin
        tmo_r <= tmo_r + TW'(1);
        if (!sfr_ack && tmo_last_s) err_r <= 1'b1;
      end
`endif
      if (load_s) begin
        if (gnt_dbg_r) dbg_rdata_r <= data_s;
        else           cpu_rdata_r <= data_s;
      end
    end
  end

  // Boot RAM byte writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (!reset && state_r == ST_BOOT) begin
      if (w_r[1]) boot_mem[boot_idx_s][15:8] <= wdata_r[15:8];
      if (w_r[0]) boot_mem[boot_idx_s][7:0]  <= wdata_r[7:0];
    end
  end

  // Strobe and handshake decode from registered state
  always_comb begin
    cpu_ready  = 1'b0;
    dbg_ready  = 1'b0;
    sfr_sel    = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    bus_err    = 1'b0;
    case (state_r)
      ST_SFR:  sfr_sel = 1'b1;
      ST_SRAM: begin
        sram_ce_n = 1'b0;
        if (rd_r) begin
          sram_oe_n = 1'b0;
          sram_ub_n = 1'b0;
          sram_lb_n = 1'b0;
        end else begin
          sram_dq_oe = 1'b1;
          sram_we_n  = (cnt_r == 4'd0);
          sram_ub_n  = ~w_r[1];
          sram_lb_n  = ~w_r[0];
        end
      end
      ST_DONE: begin
        cpu_ready = ~gnt_dbg_r;
        dbg_ready = gnt_dbg_r;
`ifdef MEMCTL_SFR_TIMEOUT_EN
        bus_err   = err_r;
`else
        bus_err   = 1'b0;
`endif
      end
      default: begin
        cpu_ready = 1'b0;
        dbg_ready = 1'b0;
      end
    endcase
  end

  assign cpu_rdata = cpu_rdata_r;
  assign dbg_rdata = dbg_rdata_r;
  assign sfr_addr  = addr_r[7:0];
  assign sfr_r     = rd_r;
  assign sfr_w     = w_r;
  assign sfr_wdata = wdata_r;
  assign sram_addr = {sram_bank, addr_r[AW-1:1]};
  assign sram_dq_o = wdata_r;

endmodule

// File: tb/tb_b16_memctl.sv
// Directed self-checking bench for b16_memctl (default parameters).
module tb_b16_memctl;

  logic        clk, reset;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_r, cpu_ready;
  logic [1:0]  cpu_w;
  logic        dbg_cs, dbg_r, dbg_ready;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [1:0]  dbg_w;
  logic        sfr_sel, sfr_r, sfr_ack;
  logic [7:0]  sfr_addr;
  logic [1:0]  sfr_w;
  logic [15:0] sfr_wdata, sfr_rdata;
  logic [2:0]  sram_bank;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  b16_memctl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_cs(dbg_cs), .dbg_addr(dbg_addr), .dbg_r(dbg_r), .dbg_w(dbg_w),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .sfr_sel(sfr_sel), .sfr_addr(sfr_addr), .sfr_r(sfr_r), .sfr_w(sfr_w),
    .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata), .sfr_ack(sfr_ack),
    .sram_bank(sram_bank), .sram_addr(sram_addr), .sram_dq_i(sram_dq_i),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_ready, dbg_ready, sfr_sel, bus_err, sram_dq_oe} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {cpu_ready, dbg_ready, sfr_sel, bus_err, sram_dq_oe});
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes: got %b expected 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    checks++;
    if (cpu_rdata !== 16'h0000 || dbg_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", cpu_rdata, dbg_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_boot();
    @(negedge clk);
    cpu_addr = 16'h2004; cpu_w = 2'b11; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL boot_wr_early: got %b expected 0", cpu_ready); end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin errors++; $display("FAIL boot_wr_ready: got %b expected 1", cpu_ready); end
    cpu_w = 2'b00;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL boot_ready_pulse: got %b expected 0", cpu_ready); end
    cpu_r = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL boot_rd: got ready=%b data=%h expected 1/beef", cpu_ready, cpu_rdata);
    end
    cpu_r = 1'b0;
    // low-byte-only write keeps the high byte
    @(negedge clk);
    cpu_w = 2'b01; cpu_wdata = 16'h1100;
    repeat (2) @(negedge clk);
    cpu_w = 2'b00;
    @(negedge clk);
    cpu_r = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hBE00) begin
      errors++; $display("FAIL boot_byte_wr: got ready=%b data=%h expected 1/be00", cpu_ready, cpu_rdata);
    end
    cpu_r = 1'b0;
  endtask

  task automatic test_sram_read();
    sram_bank = 3'b101; sram_dq_i = 16'h1234;
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_r = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n, cpu_ready} !== 7'b0010000) begin
        errors++; $display("FAIL sram_rd_cycle%0d: got %b expected 0010000", i,
          {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n, cpu_ready});
      end
      if (i == 1) begin
        checks++;
        if (sram_addr !== 18'h2C000) begin errors++; $display("FAIL sram_addr: got %h expected 2c000", sram_addr); end
      end
    end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h1234 || sram_oe_n !== 1'b1) begin
      errors++; $display("FAIL sram_rd_done: got ready=%b data=%h oe_n=%b expected 1/1234/1", cpu_ready, cpu_rdata, sram_oe_n);
    end
    cpu_r = 1'b0;
  endtask

  task automatic test_sram_byte_write();
    int we_low;
    we_low = 0;
    @(negedge clk);
    cpu_addr = 16'h8002; cpu_w = 2'b01; cpu_wdata = 16'hAA55;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) we_low++;
      checks++;
      if ({sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 4'b0101 || sram_dq_o !== 16'hAA55) begin
        errors++; $display("FAIL sram_wr_cycle%0d: got %b dq=%h expected 0101/aa55", i,
          {sram_ce_n, sram_ub_n, sram_lb_n, sram_dq_oe}, sram_dq_o);
      end
    end
    checks++;
    if (we_low !== 2) begin errors++; $display("FAIL sram_we_len: got %0d expected 2", we_low); end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h1234) begin
      errors++; $display("FAIL sram_wr_done: got ready=%b data=%h expected 1/1234", cpu_ready, cpu_rdata);
    end
    cpu_w = 2'b00;
  endtask

  task automatic test_back_to_back();
    sram_dq_i = 16'h5678;
    @(negedge clk);
    cpu_addr = 16'h8000; cpu_r = 1'b1;
    dbg_cs = 1'b1; dbg_r = 1'b1; dbg_addr = 16'h2004;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_ready !== 1'b1 || dbg_rdata !== 16'hBE00 || cpu_ready !== 1'b0 || cpu_rdata !== 16'h1234) begin
      errors++; $display("FAIL arb_dbg_first: got dready=%b ddata=%h cready=%b cdata=%h expected 1/be00/0/1234",
        dbg_ready, dbg_rdata, cpu_ready, cpu_rdata);
    end
    dbg_cs = 1'b0; dbg_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b0) begin errors++; $display("FAIL arb_cpu_early%0d: got %b expected 0", i, cpu_ready); end
    end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h5678 || dbg_ready !== 1'b0 || dbg_rdata !== 16'hBE00) begin
      errors++; $display("FAIL arb_cpu_second: got cready=%b cdata=%h dready=%b ddata=%h expected 1/5678/0/be00",
        cpu_ready, cpu_rdata, dbg_ready, dbg_rdata);
    end
    cpu_r = 1'b0;
  endtask

  task automatic test_sfr();
    sfr_rdata = 16'hC0DE; sfr_ack = 1'b1;
    @(negedge clk);
    cpu_addr = 16'hFF10; cpu_r = 1'b1;
    @(negedge clk);
    checks++;
    if (sfr_sel !== 1'b1 || sfr_addr !== 8'h10 || sfr_r !== 1'b1) begin
      errors++; $display("FAIL sfr_rd_req: got sel=%b addr=%h r=%b expected 1/10/1", sfr_sel, sfr_addr, sfr_r);
    end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hC0DE || sfr_sel !== 1'b0 || bus_err !== 1'b0) begin
      errors++; $display("FAIL sfr_rd_done: got ready=%b data=%h sel=%b err=%b expected 1/c0de/0/0",
        cpu_ready, cpu_rdata, sfr_sel, bus_err);
    end
    cpu_r = 1'b0;
    @(negedge clk);
    dbg_cs = 1'b1; dbg_w = 2'b10; dbg_addr = 16'hFF22; dbg_wdata = 16'h1357;
    @(negedge clk);
    checks++;
    if (sfr_sel !== 1'b1 || sfr_w !== 2'b10 || sfr_wdata !== 16'h1357 || sfr_addr !== 8'h22 || sfr_r !== 1'b0) begin
      errors++; $display("FAIL sfr_wr_req: got sel=%b w=%b wd=%h addr=%h r=%b expected 1/10/1357/22/0",
        sfr_sel, sfr_w, sfr_wdata, sfr_addr, sfr_r);
    end
    @(negedge clk);
    checks++;
    if (dbg_ready !== 1'b1 || dbg_rdata !== 16'hBE00) begin
      errors++; $display("FAIL sfr_wr_done: got ready=%b data=%h expected 1/be00", dbg_ready, dbg_rdata);
    end
    dbg_cs = 1'b0; dbg_w = 2'b00;
  endtask

  task automatic test_sfr_no_ack();
    sfr_ack = 1'b0; sfr_rdata = 16'h4444;
    @(negedge clk);
    cpu_addr = 16'hFF10; cpu_r = 1'b1;
`ifdef MEMCTL_SFR_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (sfr_sel !== 1'b1 || cpu_ready !== 1'b0) begin
        errors++; $display("FAIL sfr_tmo_wait%0d: got sel=%b ready=%b expected 1/0", i, sfr_sel, cpu_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || bus_err !== 1'b1 || cpu_rdata !== 16'hDEAD) begin
      errors++; $display("FAIL sfr_tmo_done: got ready=%b err=%b data=%h expected 1/1/dead", cpu_ready, bus_err, cpu_rdata);
    end
`else
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || bus_err !== 1'b0 || cpu_rdata !== 16'h4444) begin
      errors++; $display("FAIL sfr_ack_ignored: got ready=%b err=%b data=%h expected 1/0/4444", cpu_ready, bus_err, cpu_rdata);
    end
`endif
    cpu_r = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || cpu_ready !== 1'b0) begin
      errors++; $display("FAIL sfr_err_pulse: got err=%b ready=%b expected 0/0", bus_err, cpu_ready);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    cpu_addr = 16'h8004; cpu_w = 2'b11; cpu_wdata = 16'h0F0F;
    @(negedge clk);
    checks++;
    if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b expected 0", sram_we_n); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_we_n, sram_dq_oe, cpu_ready} !== 4'b1100 || cpu_rdata !== 16'h0000) begin
      errors++; $display("FAIL rst_mid_abort: got %b data=%h expected 1100/0000",
        {sram_ce_n, sram_we_n, sram_dq_oe, cpu_ready}, cpu_rdata);
    end
    reset = 1'b0; cpu_w = 2'b00;
    @(negedge clk);
    cpu_addr = 16'h2004; cpu_r = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hBE00) begin
      errors++; $display("FAIL rst_boot_kept: got ready=%b data=%h expected 1/be00", cpu_ready, cpu_rdata);
    end
    cpu_r = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 16'h0000; cpu_r = 1'b0; cpu_w = 2'b00; cpu_wdata = 16'h0000;
    dbg_cs = 1'b0; dbg_addr = 16'h0000; dbg_r = 1'b0; dbg_w = 2'b00; dbg_wdata = 16'h0000;
    sfr_rdata = 16'h0000; sfr_ack = 1'b0;
    sram_bank = 3'b000; sram_dq_i = 16'h0000;
    test_reset();
    test_boot();
    test_sram_read();
    test_sram_byte_write();
    test_back_to_back();
    test_sfr();
    test_sfr_no_ack();
    test_reset_mid_access();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
